// File: rtl/pipeline_if_buffer_if.sv
// pipeline_if_buffer_if: token, icache-return and IF->ID handshake bundle for pipeline_if_buffer
// slave: the IF buffer itself; master: the surrounding pipeline (pre_IF, icache, ID).
interface pipeline_if_buffer_if #(
  parameter int BUS_WD = 106
);
  logic                 pre_IF_IF_valid;
  logic [BUS_WD-1:0]    pre_IF_to_IF_bus;
  logic                 pre_IF_req_sent;
  logic                 IF_allowin;
  logic                 icache_data_ok;
  logic [31:0]          icache_rdata;
  logic                 ID_allowin;
  logic                 IF_ID_valid;
  logic [BUS_WD+31:0]   IF_to_ID_bus;
  modport slave (
    input  pre_IF_IF_valid, pre_IF_to_IF_bus, pre_IF_req_sent, icache_data_ok, icache_rdata, ID_allowin,
    output IF_allowin, IF_ID_valid, IF_to_ID_bus
  );
  modport master (
    output pre_IF_IF_valid, pre_IF_to_IF_bus, pre_IF_req_sent, icache_data_ok, icache_rdata, ID_allowin,
    input  IF_allowin, IF_ID_valid, IF_to_ID_bus
  );
endinterface

// File: rtl/pipeline_if_buffer.sv
// pipeline_if_buffer: IF stage token FIFO matching in-order icache returns to pre_IF fetch tokens
// Ports: clk; reset (async, active-low); flush (drops all tokens, cancels in-flight returns);
//   bus (slave): pre_IF token push/IF_allowin, icache_data_ok/icache_rdata,
//   {inst, token} to ID via IF_ID_valid/ID_allowin; cancel_busy: stale returns still pending.
// Option: define IF_DATA_BYPASS_EN to forward icache_rdata to ID in the cycle it returns.
module pipeline_if_buffer #(
  parameter int DEPTH  = 4,
  parameter int BUS_WD = 106
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  pipeline_if_buffer_if.slave bus,
  output logic                cancel_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int BD = 72;
  logic [BUS_WD-1:0] tok [DEPTH];
  logic [31:0]       inst [DEPTH];
  logic [DEPTH-1:0]  need, filled;
  logic [AW-1:0]     wr_ptr, rd_ptr, data_ptr;
  logic [AW:0]       count, outstanding;
  logic [AW+1:0]     cancel_cnt, cancel_sum;
  logic              have_pend, head_ready, head_bd, byp, push, pop, fill, dok;
  assign dok = bus.icache_data_ok;
  // data_ptr is the oldest live entry still waiting for its word; returns arrive in order
  always_comb begin
    data_ptr = rd_ptr;
    have_pend = 1'b0;
    outstanding = '0;
    for (int k = DEPTH-1; k >= 0; k--)
      if ((AW+1)'(k) < count && need[rd_ptr + AW'(k)] && !filled[rd_ptr + AW'(k)]) begin
        data_ptr = rd_ptr + AW'(k);
        have_pend = 1'b1;
        outstanding = outstanding + (AW+1)'(1);
      end
  end
  assign head_ready = count != '0 && filled[rd_ptr];
  assign head_bd = count != '0 && tok[rd_ptr][BD];
`ifdef IF_DATA_BYPASS_EN
  assign byp = count != '0 && need[rd_ptr] && !filled[rd_ptr] && dok && cancel_cnt == '0 && !head_bd;
`else
  assign byp = 1'b0;
`endif
  assign bus.IF_allowin = count != (AW+1)'(DEPTH);
  assign bus.IF_ID_valid = !head_bd && (head_ready || byp);
  assign bus.IF_to_ID_bus = bus.IF_ID_valid ? {byp ? bus.icache_rdata : inst[rd_ptr], tok[rd_ptr]} : '0;
  assign cancel_busy = cancel_cnt != '0;
  assign push = bus.pre_IF_IF_valid && bus.IF_allowin && !flush;
  // branch-delay bubbles retire silently once their word has been consumed
  assign pop = !flush && (head_bd ? head_ready : bus.IF_ID_valid && bus.ID_allowin);
  assign fill = dok && cancel_cnt == '0 && have_pend;
  assign cancel_sum = cancel_cnt + (AW+2)'(outstanding);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cancel_cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cancel_cnt <= cancel_sum > (AW+2)'(dok) ? cancel_sum - (AW+2)'(dok) : '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      cancel_cnt <= cancel_cnt - (AW+2)'(dok && cancel_cnt != '0);
    end
  // entry payload needs no reset: liveness is tracked by count alone
  always_ff @(posedge clk) begin
    if (fill) begin
      filled[data_ptr] <= 1'b1;
      inst[data_ptr] <= bus.icache_rdata;
    end
    if (push) begin
      tok[wr_ptr] <= bus.pre_IF_to_IF_bus;
      need[wr_ptr] <= bus.pre_IF_req_sent;
      filled[wr_ptr] <= !bus.pre_IF_req_sent;
      inst[wr_ptr] <= '0;
    end
  end
  assert property (@(posedge clk) disable iff (!reset) dok |-> cancel_cnt != '0 || have_pend);
endmodule

// File: tb/tb_pipeline_if_buffer.sv
// tb_pipeline_if_buffer: table vectors, hand sequences and random traffic against a queue model
module tb_pipeline_if_buffer;
  localparam int BUS_WD = 106;
  localparam int W = BUS_WD + 32;
`ifdef IF_DATA_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic v; logic [BUS_WD-1:0] tok; logic req; logic dok; logic [31:0] rdata; logic ida; logic fl;
    logic e_allow; logic e_valid; logic [31:0] e_pc; logic [31:0] e_inst; logic e_busy;
  } vec_t;
  typedef struct { logic [BUS_WD-1:0] tok; logic need; logic filled; logic [31:0] inst; } ment_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic cancel_busy;
  ment_t mq[$];
  int mcancel = 0;
  int vectors = 0;
  int miscompares = 0;
  pipeline_if_buffer_if #(.BUS_WD(BUS_WD)) bus_if ();
  pipeline_if_buffer #(.DEPTH(4), .BUS_WD(BUS_WD)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus_if), .cancel_busy(cancel_busy)
  );
  always #5 clk = ~clk;
  function automatic logic [BUS_WD-1:0] mk_tok(input logic [31:0] pc, input logic bd, input logic ex);
    logic [BUS_WD-1:0] t;
    t = '0;
    t[31:0] = pc;
    t[72] = bd;
    t[36] = ex;
    t[35:32] = ex ? 4'h4 : 4'h0;
    return t;
  endfunction
  function automatic vec_t row(input logic v, input logic [31:0] pc, input logic bd, input logic ex,
      input logic req, input logic dok, input logic [31:0] rd, input logic ida, input logic fl,
      input logic ea, input logic ev, input logic [31:0] epc, input logic [31:0] ei, input logic eb);
    vec_t r;
    r.v = v; r.tok = mk_tok(pc, bd, ex); r.req = req; r.dok = dok; r.rdata = rd; r.ida = ida; r.fl = fl;
    r.e_allow = ea; r.e_valid = ev; r.e_pc = epc; r.e_inst = ei; r.e_busy = eb;
    return r;
  endfunction
  function automatic int m_out();
    int n = 0;
    foreach (mq[i]) if (mq[i].need && !mq[i].filled) n++;
    return n;
  endfunction
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic idle_inputs();
    bus_if.pre_IF_IF_valid = 1'b0;
    bus_if.pre_IF_to_IF_bus = '0;
    bus_if.pre_IF_req_sent = 1'b0;
    bus_if.icache_data_ok = 1'b0;
    bus_if.icache_rdata = '0;
    bus_if.ID_allowin = 1'b0;
    flush = 1'b0;
  endtask
  task automatic step(input vec_t x, input bit use_exp, input string nm);
    ment_t h;
    logic e_allow, e_valid, bd, byp, pop;
    logic [W-1:0] e_bus;
    int out;
    @(negedge clk);
    bus_if.pre_IF_IF_valid = x.v;
    bus_if.pre_IF_to_IF_bus = x.tok;
    bus_if.pre_IF_req_sent = x.req;
    bus_if.icache_data_ok = x.dok;
    bus_if.icache_rdata = x.rdata;
    bus_if.ID_allowin = x.ida;
    flush = x.fl;
    #1;
    if (mq.size() > 0) h = mq[0];
    else h = '{default: '0};
    e_allow = mq.size() != 4;
    bd = mq.size() > 0 && h.tok[72];
    byp = BYP && mq.size() > 0 && h.need && !h.filled && x.dok && mcancel == 0 && !bd;
    e_valid = mq.size() > 0 && !bd && (h.filled || byp);
    e_bus = e_valid ? {byp ? x.rdata : h.inst, h.tok} : '0;
    chk({nm, " IF_allowin"}, W'(bus_if.IF_allowin), W'(e_allow));
    chk({nm, " IF_ID_valid"}, W'(bus_if.IF_ID_valid), W'(e_valid));
    chk({nm, " IF_to_ID_bus"}, bus_if.IF_to_ID_bus, e_bus);
    chk({nm, " cancel_busy"}, W'(cancel_busy), W'(mcancel != 0));
    if (use_exp) begin
      chk({nm, " tbl IF_allowin"}, W'(bus_if.IF_allowin), W'(x.e_allow));
      chk({nm, " tbl IF_ID_valid"}, W'(bus_if.IF_ID_valid), W'(x.e_valid));
      chk({nm, " tbl cancel_busy"}, W'(cancel_busy), W'(x.e_busy));
      if (x.e_valid) begin
        chk({nm, " tbl pc"}, W'(bus_if.IF_to_ID_bus[31:0]), W'(x.e_pc));
        chk({nm, " tbl inst"}, W'(bus_if.IF_to_ID_bus[W-1:BUS_WD]), W'(x.e_inst));
      end
    end
    out = m_out();
    if (x.fl) begin
      mcancel = mcancel + out - (x.dok ? 1 : 0);
      if (mcancel < 0) mcancel = 0;
      mq.delete();
    end else begin
      pop = mq.size() > 0 && (bd ? h.filled : e_valid && x.ida);
      if (x.dok) begin
        if (mcancel > 0) mcancel--;
        else
          for (int i = 0; i < mq.size(); i++)
            if (mq[i].need && !mq[i].filled) begin
              mq[i].filled = 1'b1;
              mq[i].inst = x.rdata;
              break;
            end
      end
      if (pop) void'(mq.pop_front());
      if (x.v && e_allow) mq.push_back('{tok: x.tok, need: x.req, filled: !x.req, inst: 32'h0});
    end
  endtask
  initial begin
    vec_t tbl[$];
    vec_t hs[$];
    vec_t x;
    logic [127:0] r128;
    idle_inputs();
    #3;
    chk("reset IF_allowin", W'(bus_if.IF_allowin), W'(1));
    chk("reset IF_ID_valid", W'(bus_if.IF_ID_valid), W'(0));
    chk("reset IF_to_ID_bus", bus_if.IF_to_ID_bus, W'(0));
    chk("reset cancel_busy", W'(cancel_busy), W'(0));
    #19 reset = 1'b1;
    // single fetch
    tbl.push_back(row(1, 'hBFC00000, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 'h24020001, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 'hBFC00000, 'h24020001, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    // fill and backpressure
    tbl.push_back(row(1, 'h00, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(1, 'h04, 0, 0, 1, 1, 'h11110000, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(1, 'h08, 0, 0, 1, 1, 'h11110001, 0, 0, 1, 1, 'h00, 'h11110000, 0));
    tbl.push_back(row(1, 'h0C, 0, 0, 1, 1, 'h11110002, 0, 0, 1, 1, 'h00, 'h11110000, 0));
    tbl.push_back(row(1, 'h10, 0, 0, 1, 1, 'h11110003, 0, 0, 0, 1, 'h00, 'h11110000, 0));
    tbl.push_back(row(1, 'h10, 0, 0, 1, 0, 0, 1, 0, 0, 1, 'h00, 'h11110000, 0));
    tbl.push_back(row(1, 'h10, 0, 0, 1, 0, 0, 1, 0, 1, 1, 'h04, 'h11110001, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 'h08, 'h11110002, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 'h0C, 'h11110003, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 'h11110004, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 'h10, 'h11110004, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    // address exception behind a pending fetch, then standalone
    tbl.push_back(row(1, 'h200, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(1, 'hBFC00002, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 'h22220000, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 'h200, 'h22220000, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 'hBFC00002, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(1, 'hBFC00002, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 'hBFC00002, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    // bubble drop
    tbl.push_back(row(1, 'h100, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(1, 'h104, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(1, 'h108, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 'h33330000, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 'h33330001, 1, 0, 1, 1, 'h100, 'h33330000, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 'h33330002, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 'h108, 'h33330002, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    // flush with three outstanding and a coincident return
    tbl.push_back(row(1, 'h300, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(1, 'h304, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(1, 'h308, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 'h44440000, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(row(1, 'h80000180, 0, 0, 1, 1, 'h44440001, 1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 'h44440002, 1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 'h44440003, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 'h80000180, 'h44440003, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    foreach (tbl[i]) step(tbl[i], !BYP, $sformatf("tbl%0d", i));
    // return-cycle latency: same cycle with bypass, one cycle later without
    hs.push_back(row(1, 'h400, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    hs.push_back(row(0, 0, 0, 0, 0, 1, 'h55550000, 0, 0, 1, BYP, BYP ? 'h400 : 0, BYP ? 'h55550000 : 0, 0));
    hs.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 'h400, 'h55550000, 0));
    hs.push_back(row(1, 'h404, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    hs.push_back(row(0, 0, 0, 0, 0, 1, 'h55550001, 1, 0, 1, BYP, BYP ? 'h404 : 0, BYP ? 'h55550001 : 0, 0));
    hs.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, !BYP, !BYP ? 'h404 : 0, !BYP ? 'h55550001 : 0, 0));
    hs.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    foreach (hs[i]) step(hs[i], 1'b1, $sformatf("lat%0d", i));
    for (int c = 0; c < 2000; c++) begin
      x = '{default: '0};
      r128 = {$urandom, $urandom, $urandom, $urandom};
      x.v = $urandom_range(99) < 60;
      x.tok = r128[BUS_WD-1:0];
      x.tok[72] = $urandom_range(99) < 15;
      x.req = $urandom_range(99) < 80;
      x.dok = (mcancel + m_out() > 0) && ($urandom_range(1) == 1);
      x.rdata = $urandom;
      x.ida = $urandom_range(99) < 70;
      x.fl = $urandom_range(99) < 3;
      step(x, 1'b0, $sformatf("rnd%0d", c));
    end
    // asynchronous reset while returns are still owed to flushed tokens
    step(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0, "pre_rst0");
    step(row(1, 'h500, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "pre_rst1");
    step(row(1, 'h504, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "pre_rst2");
    step(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0, "pre_rst3");
    step(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), 1'b1, "pre_rst4");
    @(posedge clk);
    #2;
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("midrst IF_allowin", W'(bus_if.IF_allowin), W'(1));
    chk("midrst IF_ID_valid", W'(bus_if.IF_ID_valid), W'(0));
    chk("midrst IF_to_ID_bus", bus_if.IF_to_ID_bus, W'(0));
    chk("midrst cancel_busy", W'(cancel_busy), W'(0));
    mq.delete();
    mcancel = 0;
    @(negedge clk);
    #2 reset = 1'b1;
    step(row(1, 'h600, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1'b1, "post_rst0");
    step(row(0, 0, 0, 0, 0, 1, 'h66660000, 0, 0, 1, BYP, BYP ? 'h600 : 0, BYP ? 'h66660000 : 0, 0), 1'b1, "post_rst1");
    step(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 'h600, 'h66660000, 0), 1'b1, "post_rst2");
    step(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1'b1, "post_rst3");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
